biquad_sequencer: RTL and testbench

- Control front-end for the single biquad `filter` datapath. It owns that datapath's Enable, x and six coefficient inputs, and captures its y output.
- Fires the filter exactly once per audio sample tick.
- Holds NUM_SETS coefficient sets written by the control side. The live set and edits to it take effect only at sample boundaries, never mid-sample.
- Sits between the sample-rate timing/voice logic and the filter instance.

---
 rtl/biquad_sequencer.sv | 120 ++++++++++++
 tb/tb_biquad_sequencer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/biquad_sequencer.sv
// Sample-rate control front-end for a single biquad datapath: banked coefficient
// storage, sample-boundary set switching, and a FEED/WAIT/CAPTURE handshake.
module biquad_sequencer #(
    parameter int NUM_SETS = 4,
    parameter int SET_W    = 2,
    parameter int FILT_LAT = 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             sample_tick,
    input  logic [15:0]      sample_in,
    input  logic             cfg_we,
    input  logic [SET_W-1:0] cfg_set,
    input  logic [2:0]       cfg_idx,
    input  logic [15:0]      cfg_data,
    output logic             cfg_err,
    input  logic             sel_req,
    input  logic [SET_W-1:0] sel_set,
    output logic [SET_W-1:0] active_set,
    output logic             filt_en,
    output logic [15:0]      filt_x,
    output logic [15:0]      filt_b0,
    output logic [15:0]      filt_b1,
    output logic [15:0]      filt_b2,
    output logic [15:0]      filt_a0,
    output logic [15:0]      filt_a1,
    output logic [15:0]      filt_a2,
    input  logic [15:0]      filt_y,
    output logic [15:0]      sample_out,
    output logic             sample_valid,
    output logic             busy,
    output logic             overrun,
    input  logic             ovr_clr
);

    typedef enum logic [1:0] {S_IDLE, S_FEED, S_WAIT, S_CAPTURE} state_t;

    // Coefficient order within a set: b0, b1, b2, a0, a1, a2 (unity = 16'h2000, Q2.13)
    localparam logic [5:0][15:0] PASS = {16'h0000, 16'h0000, 16'h2000,
                                         16'h0000, 16'h0000, 16'h2000};

    state_t                            state, state_nxt;
    logic [3:0]                        cnt;
    logic [NUM_SETS-1:0][5:0][15:0]    bank;
    logic [5:0][15:0]                  live;
    logic [SET_W-1:0]                  pending;
    logic                              dirty;
    logic                              accept, reload, cfg_ok;
    logic [SET_W-1:0]                  tgt;

    // A select arriving with the tick applies to that same sample.
    assign tgt    = sel_req ? sel_set : pending;
    assign accept = (state == S_IDLE) && sample_tick;
    assign reload = accept && (dirty || sel_req);
    assign cfg_ok = cfg_we && (cfg_idx <= 3'd5);

    assign busy    = (state != S_IDLE);
    assign filt_en = (state == S_FEED);
    assign filt_b0 = live[0];
    assign filt_b1 = live[1];
    assign filt_b2 = live[2];
    assign filt_a0 = live[3];
    assign filt_a1 = live[4];
    assign filt_a2 = live[5];

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (sample_tick) state_nxt = S_FEED;
            S_FEED:    state_nxt = S_WAIT;
            S_WAIT:    if (cnt == 4'd0) state_nxt = S_CAPTURE;
            S_CAPTURE: state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state        <= S_IDLE;
            cnt          <= 4'd0;
            filt_x       <= 16'h0000;
            sample_out   <= 16'h0000;
            sample_valid <= 1'b0;
            cfg_err      <= 1'b0;
            overrun      <= 1'b0;
            active_set   <= '0;
            pending      <= '0;
            dirty        <= 1'b1;
            live         <= PASS;
            for (int s = 0; s < NUM_SETS; s++) bank[s] <= PASS;
        end else begin
            state        <= state_nxt;
            sample_valid <= (state == S_CAPTURE);
            cfg_err      <= cfg_we && (cfg_idx > 3'd5);

            if (state == S_FEED)      cnt <= 4'(FILT_LAT - 1);
            else if (state == S_WAIT) cnt <= cnt - 4'd1;

            if (state == S_CAPTURE) sample_out <= filt_y;

            // A new overrun beats a same-cycle clear.
            if (sample_tick && busy) overrun <= 1'b1;
            else if (ovr_clr)        overrun <= 1'b0;

            if (sel_req) pending <= sel_set;

            if (accept) filt_x <= sample_in;
            if (reload) begin
                live       <= bank[tgt];
                active_set <= tgt;
            end

            // Reload reads the bank before a same-edge write, so such a write keeps dirty set.
            dirty <= (reload ? 1'b0 : (dirty | sel_req)) | (cfg_ok && (cfg_set == tgt));

            if (cfg_ok) bank[cfg_set][cfg_idx] <= cfg_data;
        end
    end

endmodule

// File: tb/tb_biquad_sequencer.sv
// Directed bench for biquad_sequencer (FILT_LAT=1): latency, set switching,
// boundary-only coefficient updates, overrun, cfg errors and mid-sample reset.
module tb_biquad_sequencer;

    logic        Clk = 1'b0;
    logic        Reset, sample_tick, cfg_we, sel_req, ovr_clr;
    logic [15:0] sample_in, cfg_data, filt_y;
    logic [1:0]  cfg_set, sel_set, active_set;
    logic [2:0]  cfg_idx;
    logic        cfg_err, filt_en, sample_valid, busy, overrun;
    logic [15:0] filt_x, filt_b0, filt_b1, filt_b2, filt_a0, filt_a1, filt_a2, sample_out;

    int checks = 0;
    int errors = 0;

    biquad_sequencer #(.NUM_SETS(4), .SET_W(2), .FILT_LAT(1)) dut (
        .Clk(Clk), .Reset(Reset), .sample_tick(sample_tick), .sample_in(sample_in),
        .cfg_we(cfg_we), .cfg_set(cfg_set), .cfg_idx(cfg_idx), .cfg_data(cfg_data),
        .cfg_err(cfg_err), .sel_req(sel_req), .sel_set(sel_set), .active_set(active_set),
        .filt_en(filt_en), .filt_x(filt_x),
        .filt_b0(filt_b0), .filt_b1(filt_b1), .filt_b2(filt_b2),
        .filt_a0(filt_a0), .filt_a1(filt_a1), .filt_a2(filt_a2),
        .filt_y(filt_y), .sample_out(sample_out), .sample_valid(sample_valid),
        .busy(busy), .overrun(overrun), .ovr_clr(ovr_clr)
    );

    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic tick(input logic [15:0] x);
        sample_tick = 1'b1;
        sample_in   = x;
        step();
        sample_tick = 1'b0;
    endtask

    task automatic wr(input logic [1:0] s, input logic [2:0] i, input logic [15:0] d);
        cfg_we = 1'b1; cfg_set = s; cfg_idx = i; cfg_data = d;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        step(); step();
        Reset = 1'b0;
        checks++;
        if ({filt_en, sample_valid, busy, overrun, cfg_err} !== 5'b0) begin
            errors++; $display("FAIL reset_flags got %b want 00000", {filt_en, sample_valid, busy, overrun, cfg_err});
        end
        checks++;
        if (active_set !== 2'd0 || sample_out !== 16'h0 || filt_x !== 16'h0) begin
            errors++; $display("FAIL reset_regs got set=%0d out=%h x=%h want 0", active_set, sample_out, filt_x);
        end
        checks++;
        if ({filt_b0, filt_b1, filt_b2, filt_a0, filt_a1, filt_a2} !== {16'h2000, 32'h0, 16'h2000, 32'h0}) begin
            errors++; $display("FAIL reset_coefs got %h %h %h %h %h %h want passthrough",
                               filt_b0, filt_b1, filt_b2, filt_a0, filt_a1, filt_a2);
        end
    endtask

    task automatic test_latency();
        filt_y = 16'h1234;
        tick(16'hECEB);                       // now T+1
        checks++;
        if (filt_en !== 1'b1 || filt_x !== 16'hECEB || busy !== 1'b1) begin
            errors++; $display("FAIL feed got en=%b x=%h busy=%b want 1 ECEB 1", filt_en, filt_x, busy);
        end
        step();                               // T+2
        checks++;
        if (filt_en !== 1'b0 || sample_valid !== 1'b0) begin
            errors++; $display("FAIL wait got en=%b vld=%b want 0 0", filt_en, sample_valid);
        end
        step();                               // T+3
        checks++;
        if (sample_valid !== 1'b0 || filt_en !== 1'b0) begin
            errors++; $display("FAIL capture got vld=%b en=%b want 0 0", sample_valid, filt_en);
        end
        step();                               // T+4
        checks++;
        if (sample_valid !== 1'b1 || sample_out !== 16'h1234 || busy !== 1'b0) begin
            errors++; $display("FAIL valid got vld=%b out=%h busy=%b want 1 1234 0", sample_valid, sample_out, busy);
        end
        checks++;
        if (filt_b0 !== 16'h2000 || filt_a0 !== 16'h2000 || filt_b1 !== 16'h0 || active_set !== 2'd0) begin
            errors++; $display("FAIL pass_coefs got b0=%h a0=%h b1=%h set=%0d want 2000 2000 0 0",
                               filt_b0, filt_a0, filt_b1, active_set);
        end
        step();
        checks++;
        if (sample_valid !== 1'b0 || sample_out !== 16'h1234) begin
            errors++; $display("FAIL valid_pulse got vld=%b out=%h want 0 1234", sample_valid, sample_out);
        end
    endtask

    task automatic test_coef_switch();
        wr(2'd1, 3'd0, 16'h1123);
        wr(2'd1, 3'd1, 16'h2246);
        wr(2'd1, 3'd2, 16'h1123);
        wr(2'd1, 3'd3, 16'h1559);
        wr(2'd1, 3'd4, 16'hFB73);
        wr(2'd1, 3'd5, 16'hEFF6);
        sel_req = 1'b1; sel_set = 2'd1;
        step();
        sel_req = 1'b0;
        step();
        checks++;
        if (filt_b0 !== 16'h2000 || filt_a1 !== 16'h0 || active_set !== 2'd0) begin
            errors++; $display("FAIL pre_tick got b0=%h a1=%h set=%0d want 2000 0 0", filt_b0, filt_a1, active_set);
        end
        tick(16'h0100);
        checks++;
        if ({filt_b0, filt_b1, filt_b2, filt_a0, filt_a1, filt_a2} !==
            {16'h1123, 16'h2246, 16'h1123, 16'h1559, 16'hFB73, 16'hEFF6} || active_set !== 2'd1) begin
            errors++; $display("FAIL switch got %h %h %h %h %h %h set=%0d want 1123 2246 1123 1559 FB73 EFF6 1",
                               filt_b0, filt_b1, filt_b2, filt_a0, filt_a1, filt_a2, active_set);
        end
        repeat (3) step();
    endtask

    task automatic test_edit_during_wait();
        tick(16'h0001);                       // T+1
        step();                               // T+2 (WAIT)
        wr(2'd1, 3'd4, 16'h0100);             // now T+3
        checks++;
        if (filt_a1 !== 16'hFB73) begin
            errors++; $display("FAIL a1_capture got %h want FB73", filt_a1);
        end
        step();                               // T+4
        checks++;
        if (filt_a1 !== 16'hFB73 || sample_valid !== 1'b1) begin
            errors++; $display("FAIL a1_hold got %h vld=%b want FB73 1", filt_a1, sample_valid);
        end
        tick(16'h0002);
        checks++;
        if (filt_a1 !== 16'h0100 || filt_b0 !== 16'h1123) begin
            errors++; $display("FAIL a1_next got a1=%h b0=%h want 0100 1123", filt_a1, filt_b0);
        end
        repeat (3) step();
    endtask

    task automatic test_overrun();
        int vcnt;
        vcnt = 0;
        filt_y = 16'h0F0F;
        tick(16'h0003);                       // T+1
        if (sample_valid) vcnt++;
        step();                               // T+2
        if (sample_valid) vcnt++;
        tick(16'h0004);                       // dropped; now T+3
        if (sample_valid) vcnt++;
        checks++;
        if (overrun !== 1'b1) begin
            errors++; $display("FAIL overrun_set got %b want 1", overrun);
        end
        for (int i = 0; i < 6; i++) begin
            step();
            if (sample_valid) vcnt++;
        end
        checks++;
        if (vcnt != 1 || overrun !== 1'b1 || sample_out !== 16'h0F0F) begin
            errors++; $display("FAIL overrun_valids got n=%0d ovr=%b out=%h want 1 1 0F0F", vcnt, overrun, sample_out);
        end
        ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;
        checks++;
        if (overrun !== 1'b0) begin
            errors++; $display("FAIL overrun_clr got %b want 0", overrun);
        end
        tick(16'h0005);                       // T+1
        sample_tick = 1'b1; ovr_clr = 1'b1;
        step();
        sample_tick = 1'b0; ovr_clr = 1'b0;
        checks++;
        if (overrun !== 1'b1) begin
            errors++; $display("FAIL overrun_wins got %b want 1", overrun);
        end
        repeat (2) step();
        ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;
    endtask

    task automatic test_cfg_err();
        wr(2'd2, 3'd6, 16'hBEEF);
        checks++;
        if (cfg_err !== 1'b1) begin
            errors++; $display("FAIL cfg_err_pulse got %b want 1", cfg_err);
        end
        step();
        checks++;
        if (cfg_err !== 1'b0) begin
            errors++; $display("FAIL cfg_err_end got %b want 0", cfg_err);
        end
        wr(2'd2, 3'd2, 16'h0042);
        checks++;
        if (cfg_err !== 1'b0) begin
            errors++; $display("FAIL cfg_err_valid_idx got %b want 0", cfg_err);
        end
        // select and tick together: set 2 used for this very sample
        sel_req = 1'b1; sel_set = 2'd2; sample_tick = 1'b1; sample_in = 16'h0006;
        step();
        sel_req = 1'b0; sample_tick = 1'b0;
        checks++;
        if ({filt_b0, filt_b1, filt_b2, filt_a0, filt_a1, filt_a2} !==
            {16'h2000, 16'h0, 16'h0042, 16'h2000, 16'h0, 16'h0} || active_set !== 2'd2) begin
            errors++; $display("FAIL set2_readback got %h %h %h %h %h %h set=%0d want 2000 0 0042 2000 0 0 2",
                               filt_b0, filt_b1, filt_b2, filt_a0, filt_a1, filt_a2, active_set);
        end
        repeat (3) step();
        // write to active set with tick: reload sees the old value
        cfg_we = 1'b1; cfg_set = 2'd2; cfg_idx = 3'd0; cfg_data = 16'h7777;
        sample_tick = 1'b1; sample_in = 16'h0007;
        step();
        cfg_we = 1'b0; sample_tick = 1'b0;
        checks++;
        if (filt_b0 !== 16'h2000) begin
            errors++; $display("FAIL same_edge_write got b0=%h want 2000", filt_b0);
        end
        repeat (3) step();
        tick(16'h0008);
        checks++;
        if (filt_b0 !== 16'h7777) begin
            errors++; $display("FAIL deferred_write got b0=%h want 7777", filt_b0);
        end
        repeat (3) step();
    endtask

    task automatic test_reset_mid_sample();
        int vcnt;
        vcnt = 0;
        tick(16'h0009);                       // T+1
        step();                               // T+2 (WAIT)
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || filt_en !== 1'b0 || sample_valid !== 1'b0) begin
            errors++; $display("FAIL abort got busy=%b en=%b vld=%b want 0 0 0", busy, filt_en, sample_valid);
        end
        checks++;
        if (filt_b0 !== 16'h2000 || filt_b2 !== 16'h0 || active_set !== 2'd0) begin
            errors++; $display("FAIL abort_coefs got b0=%h b2=%h set=%0d want 2000 0 0", filt_b0, filt_b2, active_set);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            if (sample_valid) vcnt++;
        end
        checks++;
        if (vcnt != 0) begin
            errors++; $display("FAIL abort_novalid got %0d valids want 0", vcnt);
        end
        filt_y = 16'h5A5A;
        tick(16'h1111);
        checks++;
        if (filt_en !== 1'b1 || filt_x !== 16'h1111) begin
            errors++; $display("FAIL post_reset_feed got en=%b x=%h want 1 1111", filt_en, filt_x);
        end
        repeat (3) step();
        checks++;
        if (sample_valid !== 1'b1 || sample_out !== 16'h5A5A) begin
            errors++; $display("FAIL post_reset_valid got vld=%b out=%h want 1 5A5A", sample_valid, sample_out);
        end
    endtask

    initial begin
        Reset = 1'b1; sample_tick = 1'b0; sample_in = 16'h0; cfg_we = 1'b0;
        cfg_set = 2'd0; cfg_idx = 3'd0; cfg_data = 16'h0; sel_req = 1'b0;
        sel_set = 2'd0; ovr_clr = 1'b0; filt_y = 16'h0;
        #1;
        test_reset();
        test_latency();
        test_coef_switch();
        test_edit_during_wait();
        test_overrun();
        test_cfg_err();
        test_reset_mid_sample();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
